// File: rtl/ifetch_queue_pkg.sv
// Shared types for the instruction-fetch queue: bus request/response,
// queued fetch entry and fetch FSM state encoding.
package ifetch_queue_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef logic [1:0] fq_state_t;

  localparam fq_state_t FQ_IDLE = 2'd0;
  localparam fq_state_t FQ_WAIT = 2'd1;
  localparam fq_state_t FQ_DROP = 2'd2;

endpackage

// File: rtl/ifq_ring.sv
// DEPTH-entry ring buffer of fetch entries; clear dominates push and pop.
// The caller never pushes when full unless it also pops in the same cycle.
module ifq_ring
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear && !reset) mem[tail] <= din;
  end

  assign dout = mem[head];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: owns the fetch PC, keeps one ibus request in
// flight and buffers returned instructions with their PCs for the IF stage.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  output ibus_req_t               ireq,
  input  ibus_resp_t              iresp,
  input  logic                    redirect_valid,
  input  logic [63:0]             redirect_pc,
  output logic                    out_valid,
  output logic [63:0]             out_pc,
  output logic [31:0]             out_instr,
  input  logic                    out_ready,
  output fq_state_t               dbg_state,
  output logic [$clog2(DEPTH):0]  dbg_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  fq_state_t      state;
  logic [63:0]    fetch_pc;
  logic [63:0]    req_addr;
  logic [CW-1:0]  count;
  logic           issue;
  logic           push;
  logic           pop;
  fetch_entry_t   head;

  // Handshakes: ireq.valid, once raised, holds with a stable addr until the
  // cycle iresp.data_ok is 1; the head transfers when out_valid && out_ready.
  always_comb begin
    issue      = (state == FQ_IDLE) && (count < CW'(DEPTH)) && !redirect_valid;
    ireq.valid = !reset && (issue || (state != FQ_IDLE));
    ireq.addr  = (state == FQ_IDLE) ? fetch_pc : req_addr;
  end

  assign push = (state == FQ_WAIT) && iresp.data_ok && !redirect_valid;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FQ_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      // An outstanding request must still complete on the bus; its data is discarded.
      if (state != FQ_IDLE) state <= iresp.data_ok ? FQ_IDLE : FQ_DROP;
    end else begin
      case (state)
        FQ_IDLE: begin
          if (issue) begin
            req_addr <= fetch_pc;
            fetch_pc <= fetch_pc + 64'd4;
            state    <= FQ_WAIT;
          end
        end
        FQ_WAIT, FQ_DROP: begin
          if (iresp.data_ok) state <= FQ_IDLE;
        end
        default: state <= FQ_IDLE;
      endcase
    end
  end

  ifq_ring #(.DEPTH(DEPTH)) u_ring (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .din   ({req_addr, iresp.data}),
    .dout  (head),
    .count (count)
  );

  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign dbg_state = state;
  assign dbg_count = count;

endmodule
